// File: rtl/inst_fetch.sv
// inst_fetch: PC owner and instruction-bus master with delay-slot branch, flush/kill and a one-entry skid buffer
module inst_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
);
  typedef enum logic [1:0] {IDLE, REQ, KILL, HOLD} state_t;
  state_t state, state_n;
  logic [31:0] pc, req_addr, skid_pc, skid_inst, seq_addr;
  logic hold;
  assign hold = stall[0];
  assign seq_addr = branch_flag_i ? branch_target_address_i : req_addr + 32'd4;
  assign ibus_req = (state == REQ) || (state == KILL);
  assign ibus_addr = req_addr;
  assign stallreq_if = (state == IDLE) || (state == KILL) || (state == REQ && !ibus_ack);
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = (!hold && !flush) ? REQ : IDLE;
      REQ:  state_n = (flush && !ibus_ack) ? KILL : (ibus_ack && hold && !flush) ? HOLD : REQ;
      KILL: state_n = (!flush && ibus_ack) ? REQ : KILL;
      HOLD: state_n = (flush || !hold) ? REQ : HOLD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pc <= RESET_ADDR;
      req_addr <= RESET_ADDR;
      skid_pc <= '0;
      skid_inst <= '0;
      if_pc <= '0;
      if_inst <= '0;
    end else begin
      state <= state_n;
      if (flush) begin
        pc <= new_pc;
        if_pc <= '0;
        if_inst <= '0;
        if ((state == REQ && ibus_ack) || state == HOLD) req_addr <= new_pc;
      end else begin
        case (state)
          IDLE: if (!hold) req_addr <= pc;
          REQ: if (ibus_ack) begin
            pc <= seq_addr;
            req_addr <= seq_addr;
            if (hold) begin
              skid_pc <= req_addr;
              skid_inst <= ibus_rdata;
            end else begin
              if_pc <= req_addr;
              if_inst <= ibus_rdata;
            end
          end
          KILL: if (ibus_ack) req_addr <= pc;
          HOLD: if (!hold) begin
            if_pc <= skid_pc;
            if_inst <= skid_inst;
            req_addr <= pc;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the five-stage pipeline: owns the program counter, issues instruction-bus reads, and drives the fetched PC/instruction pair into the IF/ID pipeline register. It implements one-delay-slot branch redirect from ID, exception flush from the control unit, and a one-entry skid buffer so that a response arriving during a pipeline stall is never lost. It raises a stall request to the pipeline controller while memory is slow.

## Interface
- RESET_ADDR, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- stall  in  6  pipeline controller stall vector; bit 0 = hold fetch stage
- flush  in  1  exception flush, highest priority
- new_pc  in  32  flush target, valid with flush
- branch_flag_i  in  1  ID-stage branch taken
- branch_target_address_i  in  32  branch target, valid with branch_flag_i
- ibus_req  out  1  read request to instruction bus
- ibus_addr  out  32  word-aligned read address
- ibus_ack  in  1  read complete this cycle; ibus_rdata valid
- ibus_rdata  in  32  instruction word
- if_pc  out  32  PC of fetched instruction, to IF/ID
- if_inst  out  32  fetched instruction, to IF/ID
- stallreq_if  out  1  fetch not ready, to pipeline controller

## Operation
- Registers: pc (next fetch address), req_addr, state, skid_pc/skid_inst, if_pc/if_inst.
- States: IDLE, REQ, KILL, HOLD. ibus_req = (state==REQ || state==KILL); ibus_addr = req_addr.
- Bus rule: once ibus_req is high, ibus_req and ibus_addr stay stable until the edge where ibus_ack=1.
- IDLE: if stall[0]==0, next state REQ, req_addr<=pc; otherwise stay in IDLE.
- REQ, ack, stall[0]==0: if_pc<=req_addr, if_inst<=ibus_rdata; pc and req_addr <= branch_flag_i ? branch_target_address_i : req_addr+4; stay REQ.
- REQ, ack, stall[0]==1: skid<= {req_addr, rdata}; pc updated as above; go to HOLD.
- REQ, no ack: hold everything.
- HOLD: ibus_req low. When stall[0]==0: if_pc/if_inst<=skid; req_addr<=pc; go to REQ.
- Delay slot: a branch never kills the in-flight fetch. That fetch is the delay slot. branch_flag_i is sampled only on the completing (ack) edge; the controller holds ID stable until then.
- flush, which overrides the branch:
  - pc<=new_pc; if_pc<=0; if_inst<=0 (NOP).
  - REQ without ack: go to KILL.
  - REQ with ack: discard the data, req_addr<=new_pc, stay REQ.
  - HOLD: discard the skid entry, req_addr<=new_pc, go to REQ.
  - IDLE: stay IDLE.
  - KILL: update pc, stay KILL.
- KILL: keep the old request until ack, then drop the data, req_addr<=pc, go to REQ.
- stallreq_if = IDLE || KILL || (REQ && !ibus_ack). It is 0 in HOLD.
- PC arithmetic: 32-bit, +4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). No alignment checking.

## Timing
- Reset (rst==0, async): state=IDLE, pc=req_addr=RESET_ADDR, if_pc=0, if_inst=0, skid=0, ibus_req=0, ibus_addr=RESET_ADDR, stallreq_if=1.
- First ibus_req is high in the first cycle after the first edge with rst high and stall[0]==0.
- Latency: with zero-wait memory (ack in the request cycle), if_pc/if_inst update on that edge. Throughput is 1 instruction/cycle.
- Each memory wait cycle adds one cycle, with stallreq_if high for that cycle.
- Reset asserted mid-request: immediate return to reset values. A later stray ack while in IDLE is ignored.
- Simultaneous flush and branch_flag_i: flush wins.
- Simultaneous flush and ack: the data is dropped with no KILL cycle.

## Test plan
- Zero-wait memory, ack tied 1, returning rdata=addr^32'hA5A5_0000 -> ibus_addr sequence 0,4,8,12; if_pc lags by 0 edges; if_inst matches; stallreq_if=0 after the first cycle.
- Ack delayed 2 cycles per fetch -> ibus_addr stable across the wait; stallreq_if=1 for 2 cycles per fetch; one instruction every 3 cycles.
- Branch at ack of fetch 0x10, target 0x100 -> the 0x10 instruction is delivered (delay slot), next ibus_addr=0x100.
- Flush with new_pc=0x180 while the request to 0x20 is waiting -> KILL: addr 0x20 held until ack, data dropped, if_inst=0, next ibus_addr=0x180.
- stall[0]=1 when ack returns for 0x8 -> if_pc/if_inst unchanged, ibus_req=0. When stall drops, if_pc=0x8 with the correct inst, then a request to 0xC.
- Reset pulse (rst=0) asynchronously mid-wait at pc 0x40 -> outputs go to reset values immediately. After release, the first request is to RESET_ADDR.
